// File: rtl/jk_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_count_ctrl
// Description : Command-driven sequencer for a bank of WIDTH JK flip-flop
//               stages. It accepts CLEAR, LOAD, COUNT and STOP commands over a
//               valid/ready handshake. It generates a {j,k} code for each stage
//               and uses those codes to step the bank. A COUNT of N steps moves
//               q by exactly one per cycle, up or down, modulo 2^WIDTH. done
//               pulses for one cycle when a COUNT completes.
//
// Ports       : clk        - single clock, all state changes on posedge
//               rst_n      - asynchronous active-low reset
//               cmd_valid  - command present
//               cmd_ready  - command accepted when valid & ready at posedge
//               cmd_op     - 00 CLEAR, 01 LOAD, 10 COUNT, 11 STOP
//               cmd_data   - LOAD value or COUNT step count N
//               dir        - COUNT direction, sampled on accept (1 up, 0 down)
//               jk_vec     - per-stage {j,k}, bits [2i+1:2i] for stage i
//               q          - current value of the JK stage bank
//               busy       - high whenever not IDLE
//               done       - one-cycle pulse on COUNT completion
//               err        - (JK_COUNT_CTRL_ERR_EN only) one-cycle pulse for
//                            each CLEAR/LOAD/COUNT discarded while running
//
// Macro       : JK_COUNT_CTRL_ERR_EN - adds the err output
//
// Revision    : 1.0 - initial release
// ============================================================================
module jk_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               dir,
    output logic [2*WIDTH-1:0] jk_vec,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done
`ifdef JK_COUNT_CTRL_ERR_EN
    ,
    output logic               err
`endif
);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_CLR  = 3'd1;
    localparam logic [2:0] c_S_LOAD = 3'd2;
    localparam logic [2:0] c_S_RUN  = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    localparam logic [1:0] c_OP_CLEAR = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_COUNT = 2'b10;
    localparam logic [1:0] c_OP_STOP  = 2'b11;

    localparam logic [1:0] c_JK_HOLD = 2'b00;
    localparam logic [1:0] c_JK_RST  = 2'b01;
    localparam logic [1:0] c_JK_SET  = 2'b10;
    localparam logic [1:0] c_JK_TOG  = 2'b11;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_dir;
    logic [WIDTH-1:0]   r_ld;
    logic [2*WIDTH-1:0] w_jk;
    logic [WIDTH-1:0]   w_carry;
    logic               w_ready;
    logic               w_accept;
    logic               w_stop;

    assign w_ready  = (r_state == c_S_IDLE) || (r_state == c_S_RUN);
    assign w_accept = cmd_valid && w_ready;
    assign w_stop   = w_accept && (cmd_op == c_OP_STOP);

    // Stage i toggles when every lower stage is at the roll-over value for
    // the latched direction: all ones counting up, all zeros counting down.
    assign w_carry[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign w_carry[gi] = r_dir ? (&r_q[gi-1:0]) : ~(|r_q[gi-1:0]);
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_jk         = '0;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_CLEAR: w_next_state = c_S_CLR;
                        c_OP_LOAD:  w_next_state = c_S_LOAD;
                        c_OP_COUNT: w_next_state = (cmd_data == '0) ? c_S_DONE : c_S_RUN;
                        default:    w_next_state = c_S_IDLE;
                    endcase
                end
            end
            c_S_CLR: begin
                for (int i = 0; i < WIDTH; i++) w_jk[2*i +: 2] = c_JK_RST;
                w_next_state = c_S_IDLE;
            end
            c_S_LOAD: begin
                for (int i = 0; i < WIDTH; i++) w_jk[2*i +: 2] = r_ld[i] ? c_JK_SET : c_JK_RST;
                w_next_state = c_S_IDLE;
            end
            c_S_RUN: begin
                // A STOP accepted this cycle holds every stage so no step is
                // applied on the edge that returns to IDLE.
                if (w_stop) begin
                    w_next_state = c_S_IDLE;
                end else begin
                    for (int i = 0; i < WIDTH; i++) w_jk[2*i +: 2] = w_carry[i] ? c_JK_TOG : c_JK_HOLD;
                    if (r_cnt == c_ONE) w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_next_state;
    end

    // JK stage bank, one flip-flop per stage driven by its {j,k} pair.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q[gi] <= 1'b0;
                end else begin
                    case (w_jk[2*gi +: 2])
                        c_JK_RST: r_q[gi] <= 1'b0;
                        c_JK_SET: r_q[gi] <= 1'b1;
                        c_JK_TOG: r_q[gi] <= ~r_q[gi];
                        default:  r_q[gi] <= r_q[gi];
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dir <= 1'b0;
            r_ld  <= '0;
        end else if (r_state == c_S_IDLE) begin
            if (w_accept && (cmd_op == c_OP_LOAD)) r_ld <= cmd_data;
            if (w_accept && (cmd_op == c_OP_COUNT)) begin
                r_cnt <= cmd_data;
                r_dir <= dir;
            end
        end else if ((r_state == c_S_RUN) && !w_stop) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

`ifdef JK_COUNT_CTRL_ERR_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= (r_state == c_S_RUN) && w_accept && (cmd_op != c_OP_STOP);
    end
    assign err = r_err;
`endif

    assign cmd_ready = w_ready;
    assign jk_vec    = w_jk;
    assign q         = r_q;
    assign busy      = (r_state != c_S_IDLE);
    assign done      = (r_state == c_S_DONE);

endmodule
`default_nettype wire
